// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 16;
    localparam int RR_MAX     = 8;

    // Returns {found, index}: first set bit of vec at or above ptr, wrapping at n.
    function automatic logic [3:0] rr_search(
        input logic [RR_MAX-1:0] vec,
        input logic [2:0]        ptr,
        input int                n
    );
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && vec[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick of the first requester at or after a pointer.
// Used by fifo_wr_arbiter (ARB_STATS_EN has no effect here).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [3:0] res;

    always_comb begin
        res     = rr_search(RR_MAX'(vec_i), 3'(ptr_i), N);
        idx_o   = IW'(res[2:0]);
        found_o = res[3];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define ARB_STATS_EN to add stall_cnt/grant_cnt statistics outputs.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 10,
    parameter int MAX_BURST  = 4,
    localparam int ID_WIDTH  = $clog2(NUM_REQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_enable,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
`ifdef ARB_STATS_EN
    output logic [STAT_WIDTH-1:0]         stall_cnt,
    output logic [STAT_WIDTH-1:0]         grant_cnt,
`endif
    output logic                          busy
);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0] pick_idx, next_ptr;
    logic                pick_found;
    logic                in_burst, can_take, gnt_valid, gnt_last;
    logic                xfer, burst_end;
    logic [DATA_WIDTH-1:0] gnt_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_pick (
        .vec_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign in_burst = (state_q == BURST);
    // Reset gates the handshake so nothing is written on the reset cycle.
    assign can_take = in_burst & ~fifo_full & ~reset;

    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                gnt_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_valid    = req_valid[i];
                gnt_last     = req_last[i];
                req_ready[i] = can_take;
            end
        end
    end

    assign xfer      = can_take & gnt_valid;
    assign burst_end = ~gnt_valid
                     | (xfer & (gnt_last
                     | ((beat_cnt_q + BW'(1)) == BW'(MAX_BURST))));
    assign next_ptr  = (grant_id_q == ID_WIDTH'(NUM_REQ - 1))
                     ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (burst_end) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy          = in_burst;
    assign grant_id      = grant_id_q;
    assign fifo_w_enable = xfer;
    assign fifo_wr_data  = in_burst ? gnt_data : '0;

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stall_q, grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            grant_q <= '0;
        end else begin
            if (in_burst && gnt_valid && fifo_full && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!in_burst && pick_found && grant_q != '1) begin
                grant_q <= grant_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign grant_cnt = grant_q;
`endif

endmodule
